// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared definitions for the data-memory responder: RV32I access
//            size codes, the responder state type and the byte-lane mask
//            helper used by the store path.
// Revision : 1.0  initial release
// ============================================================================
package dmem_pkg;

    // RV32I funct3 access-size codes
    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // Lane mask for an access of the given size at the given byte offset.
    // Only size[1:0] matters, so the unsigned load codes share the mask of
    // their signed counterparts and the unused codes fall into the word case.
    function automatic logic [3:0] byte_en(input logic [2:0] size,
                                           input logic [1:0] addr);
        logic [3:0] be;
        case (size[1:0])
            2'b00:   be = 4'b0001 << addr;
            2'b01:   be = addr[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder_if
// Purpose  : Request/response bundle between the core data port (master) and
//            the data-memory responder (slave).
// Signals  : req_valid/req_ready handshake, req_we, req_size (funct3),
//            req_addr (byte address), req_wdata (right-aligned store data),
//            rsp_valid (one-cycle pulse), rsp_rdata (extended load data),
//            rsp_err (request rejected, qualified by rsp_valid).
// Revision : 1.0  initial release
// ============================================================================
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lane_align
// Purpose  : Combinational byte-lane steering for RV32I sub-word accesses.
//            Store side: lane enables and write-data replication.
//            Load side : lane/half extraction with sign or zero extension.
// Ports    : i_size (funct3), i_addr_lo (byte offset), i_wdata (right-aligned
//            store data), i_rword (addressed memory word); o_be (lane
//            enables), o_wdata (replicated store data), o_rdata (extended
//            load data), o_err (request rejected).
// Config   : DMEM_MISALIGN_ERR_EN - reject misaligned and undefined sizes
//            instead of masking the offset to natural alignment.
// Revision : 1.0  initial release
// ============================================================================
module dmem_lane_align
    import dmem_pkg::*;
(
    input  wire logic [2:0]  i_size,
    input  wire logic [1:0]  i_addr_lo,
    input  wire logic [31:0] i_wdata,
    input  wire logic [31:0] i_rword,
    output logic      [3:0]  o_be,
    output logic      [31:0] o_wdata,
    output logic      [31:0] o_rdata,
    output logic             o_err
);

    logic       w_is_byte;
    logic       w_is_half;
    logic       w_unsigned;
    logic [1:0] w_off;
    logic       w_err;
    logic [7:0] w_byte;
    logic [15:0] w_half;

    assign w_is_byte  = (i_size[1:0] == 2'b00);
    assign w_is_half  = (i_size[1:0] == 2'b01);
    assign w_unsigned = i_size[2];

`ifdef DMEM_MISALIGN_ERR_EN
    // Codes 011/110/111 are undefined and rejected alongside misalignment.
    assign w_err = (i_size == 3'b011) || (i_size[2:1] == 2'b11) ||
                   (w_is_half && i_addr_lo[0]) ||
                   (!w_is_byte && !w_is_half && (i_addr_lo != 2'b00));
    assign w_off = i_addr_lo;
`else
    // Offsets are forced to natural alignment; undefined codes act as W.
    assign w_err = 1'b0;
    assign w_off = w_is_byte ? i_addr_lo :
                   w_is_half ? {i_addr_lo[1], 1'b0} : 2'b00;
`endif

    assign o_err = w_err;
    assign o_be  = w_err ? 4'b0000 : byte_en(i_size, w_off);

    // Replicate store data across every lane; o_be picks the live ones.
    always_comb begin
        o_wdata = i_wdata;
        if (w_is_byte)
            o_wdata = {4{i_wdata[7:0]}};
        else if (w_is_half)
            o_wdata = {2{i_wdata[15:0]}};
    end

    always_comb begin
        w_byte = i_rword[7:0];
        case (w_off)
            2'd0: w_byte = i_rword[7:0];
            2'd1: w_byte = i_rword[15:8];
            2'd2: w_byte = i_rword[23:16];
            2'd3: w_byte = i_rword[31:24];
            default: w_byte = i_rword[7:0];
        endcase
    end

    assign w_half = w_off[1] ? i_rword[31:16] : i_rword[15:0];

    always_comb begin
        o_rdata = i_rword;
        if (w_err)
            o_rdata = 32'd0;
        else if (w_is_byte)
            o_rdata = {{24{~w_unsigned & w_byte[7]}}, w_byte};
        else if (w_is_half)
            o_rdata = {{16{~w_unsigned & w_half[15]}}, w_half};
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Data-memory responder for the core data port. Accepts one
//            load/store request at a time, waits WAIT_STATES cycles, performs
//            the access on a byte-lane word array and returns a one-cycle
//            response pulse with extended load data.
// Ports    : clk (rising edge), reset (asynchronous, active-high),
//            bus (dmem_responder_if.slave: request handshake and response).
// Params   : DEPTH_WORDS - 32-bit words in the array (power of two, >= 4)
//            WAIT_STATES - cycles between accept and access (0..15)
// Config   : DMEM_MISALIGN_ERR_EN - reject misaligned/undefined requests with
//            rsp_err instead of masking the address to natural alignment.
// Revision : 1.0  initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  wire logic        clk,
    input  wire logic        reset,
    dmem_responder_if.slave  bus
);

    localparam int         c_IDX_W = $clog2(DEPTH_WORDS);
    localparam int         c_ADR_W = c_IDX_W + 2;
    localparam logic [3:0] c_WAIT  = 4'(WAIT_STATES);

    dmem_state_t          r_state;
    logic [3:0]           r_cnt;
    logic                 r_ready;
    logic                 r_valid;
    logic [31:0]          r_rdata;
    logic                 r_err;
    logic                 r_we;
    logic [2:0]           r_size;
    logic [c_ADR_W-1:0]   r_addr;
    logic [31:0]          r_wdata;

    logic [31:0]          r_mem [DEPTH_WORDS];

    logic                 w_accept;
    logic                 w_do_access;
    logic                 w_acc_we;
    logic [2:0]           w_acc_size;
    logic [c_ADR_W-1:0]   w_acc_addr;
    logic [31:0]          w_acc_wdata;
    logic [c_IDX_W-1:0]   w_idx;
    logic [31:0]          w_rword;
    logic [3:0]           w_be;
    logic [31:0]          w_wdata_rep;
    logic [31:0]          w_rdata_ext;
    logic                 w_err;
    logic                 w_unused_addr;

    // Address bits above the array index alias and are deliberately dropped.
    assign w_unused_addr = ^bus.req_addr[31:c_ADR_W];

    assign w_accept = bus.req_valid && r_ready;

    // With zero wait states the access happens on the accept edge itself, so
    // it must use the live request rather than the latched copy.
    generate
        if (WAIT_STATES == 0) begin : g_direct
            assign w_acc_we    = bus.req_we;
            assign w_acc_size  = bus.req_size;
            assign w_acc_addr  = bus.req_addr[c_ADR_W-1:0];
            assign w_acc_wdata = bus.req_wdata;
            assign w_do_access = w_accept;
        end else begin : g_latched
            assign w_acc_we    = r_we;
            assign w_acc_size  = r_size;
            assign w_acc_addr  = r_addr;
            assign w_acc_wdata = r_wdata;
            assign w_do_access = (r_state == WAIT) && (r_cnt == 4'd1);
        end
    endgenerate

    assign w_idx   = w_acc_addr[c_ADR_W-1:2];
    assign w_rword = r_mem[w_idx];

    dmem_lane_align u_align (
        .i_size    (w_acc_size),
        .i_addr_lo (w_acc_addr[1:0]),
        .i_wdata   (w_acc_wdata),
        .i_rword   (w_rword),
        .o_be      (w_be),
        .o_wdata   (w_wdata_rep),
        .o_rdata   (w_rdata_ext),
        .o_err     (w_err)
    );

    // Array has no reset: contents survive reset by design.
    always_ff @(posedge clk) begin
        if (!reset && w_do_access && w_acc_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i])
                    r_mem[w_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
            r_we    <= 1'b0;
            r_size  <= 3'd0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
        end else begin
            // Response data/err change only on an access and hold otherwise.
            if (w_do_access) begin
                r_rdata <= w_acc_we ? 32'd0 : w_rdata_ext;
                r_err   <= w_err;
            end

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_we    <= bus.req_we;
                        r_size  <= bus.req_size;
                        r_addr  <= bus.req_addr[c_ADR_W-1:0];
                        r_wdata <= bus.req_wdata;
                        r_ready <= 1'b0;
                        if (WAIT_STATES == 0) begin
                            r_state <= RESP;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= c_WAIT;
                        end
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= RESP;
                        r_valid <= 1'b1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready = r_ready;
    assign bus.rsp_valid = r_valid;
    assign bus.rsp_rdata = r_rdata;
`ifdef DMEM_MISALIGN_ERR_EN
    assign bus.rsp_err   = r_err;
`else
    assign bus.rsp_err   = 1'b0;
`endif

endmodule
`default_nettype wire
